regfile_seq_ctrl: RTL

- Moore FSM controller that sequences the 8x16 register file and the shared ALU datapath for one instruction at a time.
- Sits between the instruction source and the datapath.
- Latches a 16-bit instruction on start, then steps through read, ALU and write-back states, driving the regfile read/write ports and the datapath load/select strobes.
- Handshake is a level start input `s` plus a wait/idle output `w`.

---
 rtl/regfile_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl
// ----------------
// Moore controller that sequences an 8x16 register file and a shared ALU
// datapath for one instruction at a time. A 16-bit instruction is latched
// into IR when the level start input s is seen in WAIT. The controller then
// steps through decode, operand read, ALU and write-back states.
//
// Configuration macro: ILLEGAL_TRAP_EN
//   Defined   : an undecoded instruction parks the controller in TRAP
//               (illegal = 1, w = 0) until reset.
//   Undefined : an undecoded instruction returns silently to WAIT and
//               illegal is tied to 0.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   s         in   start, sampled only in WAIT
//   instr     in   instruction, captured into IR when start is accepted
//   w         out  1 while waiting for a new instruction
//   readnum   out  regfile read index
//   writenum  out  regfile write index
//   write     out  regfile write enable
//   loada/loadb/loadc/loads  out  datapath register loads (A, B, C, status)
//   asel      out  1 forces ALU A input to zero
//   bsel      out  1 selects sximm5 as ALU B input
//   vsel      out  regfile write source: 0 = C, 1 = sximm8
//   shift     out  shifter control
//   aluop     out  00 add, 01 sub, 10 and, 11 not-B
//   sximm8    out  IR[7:0] sign-extended
//   sximm5    out  IR[4:0] sign-extended
//   illegal   out  sticky undecoded-instruction flag (trap build only)
//
// The control outputs are registered: each edge loads the decode of the
// state being entered, so they follow the current state and IR exactly as
// a Moore decode would, but come straight from flops.

module regfile_seq_ctrl #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic [DW-1:0] instr,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic          vsel,
  output logic [1:0]    shift,
  output logic [1:0]    aluop,
  output logic [DW-1:0] sximm8,
  output logic [DW-1:0] sximm5,
  output logic          illegal
);

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [3:0] {
    S_WAIT   = 4'd0,
    S_DECODE = 4'd1,
    S_GET_A  = 4'd2,
    S_GET_B  = 4'd3,
    S_ALU    = 4'd4,
    S_CMP    = 4'd5,
    S_WR_REG = 4'd6,
    S_WR_IMM = 4'd7,
    S_TRAP   = 4'd8
  } state_t;
`else
  typedef enum logic [3:0] {
    S_WAIT   = 4'd0,
    S_DECODE = 4'd1,
    S_GET_A  = 4'd2,
    S_GET_B  = 4'd3,
    S_ALU    = 4'd4,
    S_CMP    = 4'd5,
    S_WR_REG = 4'd6,
    S_WR_IMM = 4'd7
  } state_t;
`endif

  // {opcode, op} encodings recognised by DECODE
  localparam logic [4:0] OP_MOV_IMM = 5'b110_10;
  localparam logic [4:0] OP_MOV_REG = 5'b110_00;
  localparam logic [4:0] OP_ADD     = 5'b101_00;
  localparam logic [4:0] OP_CMP     = 5'b101_01;
  localparam logic [4:0] OP_AND     = 5'b101_10;
  localparam logic [4:0] OP_MVN     = 5'b101_11;

  typedef struct packed {
    logic          w;
    logic [RW-1:0] readnum;
    logic [RW-1:0] writenum;
    logic          write;
    logic          loada;
    logic          loadb;
    logic          loadc;
    logic          loads;
    logic          asel;
    logic          bsel;
    logic          vsel;
    logic [1:0]    shift;
    logic [1:0]    aluop;
    logic          illegal;
  } ctrl_t;

  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] ir;
  logic [DW-1:0] ir_nx;
  ctrl_t         ctrl_r;
  logic [4:0]    opc_op;

  // Control word for a given state, with register fields taken from ir.
  function automatic ctrl_t ctrl_of(input state_t st, input logic [DW-1:0] ir_v);
    ctrl_t       c;
    logic [4:0]  code;
    code = {ir_v[15:13], ir_v[12:11]};
    c = '0;
    case (st)
      S_WAIT: begin
        c.w = 1'b1;
      end
      S_GET_A: begin
        c.readnum = ir_v[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = ir_v[2:0];
        c.loadb   = 1'b1;
        c.shift   = ir_v[4:3];
      end
      S_ALU: begin
        c.loadc = 1'b1;
        c.shift = ir_v[4:3];
        // MOV-reg and MVN pass only the B operand through the ALU
        c.asel  = (code == OP_MOV_REG) || (code == OP_MVN);
        case (code)
          OP_AND:  c.aluop = 2'b10;
          OP_MVN:  c.aluop = 2'b11;
          default: c.aluop = 2'b00;
        endcase
      end
      S_CMP: begin
        c.loads = 1'b1;
        c.aluop = 2'b01;
      end
      S_WR_REG: begin
        c.write    = 1'b1;
        c.writenum = ir_v[7:5];
      end
      S_WR_IMM: begin
        c.write    = 1'b1;
        c.writenum = ir_v[10:8];
        c.vsel     = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        c.illegal = 1'b1;
      end
`endif
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  assign opc_op = {ir[15:13], ir[12:11]};

  // Next-state and next-IR selection.
  always_comb begin
    state_nx = state;
    ir_nx    = ir;
    case (state)
      S_WAIT: begin
        if (s) begin
          ir_nx    = instr;
          state_nx = S_DECODE;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_DECODE: begin
        case (opc_op)
          OP_MOV_IMM: state_nx = S_WR_IMM;
          OP_MOV_REG: state_nx = S_GET_B;
          OP_ADD:     state_nx = S_GET_A;
          OP_CMP:     state_nx = S_GET_A;
          OP_AND:     state_nx = S_GET_A;
          OP_MVN:     state_nx = S_GET_B;
`ifdef ILLEGAL_TRAP_EN
          default:    state_nx = S_TRAP;
`else
          default:    state_nx = S_WAIT;
`endif
        endcase
      end
      S_GET_A: begin
        state_nx = S_GET_B;
      end
      S_GET_B: begin
        if (opc_op == OP_CMP) begin
          state_nx = S_CMP;
        end else begin
          state_nx = S_ALU;
        end
      end
      S_ALU: begin
        state_nx = S_WR_REG;
      end
      S_CMP: begin
        state_nx = S_WAIT;
      end
      S_WR_REG: begin
        state_nx = S_WAIT;
      end
      S_WR_IMM: begin
        state_nx = S_WAIT;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        state_nx = S_TRAP;
      end
`endif
      default: begin
        state_nx = S_WAIT;
      end
    endcase
  end

  // State, IR and registered control word; reset abandons any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_WAIT;
      ir     <= '0;
      ctrl_r <= ctrl_of(S_WAIT, '0);
    end else begin
      state  <= state_nx;
      ir     <= ir_nx;
      ctrl_r <= ctrl_of(state_nx, ir_nx);
    end
  end

  assign w        = ctrl_r.w;
  assign readnum  = ctrl_r.readnum;
  assign writenum = ctrl_r.writenum;
  assign write    = ctrl_r.write;
  assign loada    = ctrl_r.loada;
  assign loadb    = ctrl_r.loadb;
  assign loadc    = ctrl_r.loadc;
  assign loads    = ctrl_r.loads;
  assign asel     = ctrl_r.asel;
  assign bsel     = ctrl_r.bsel;
  assign vsel     = ctrl_r.vsel;
  assign shift    = ctrl_r.shift;
  assign aluop    = ctrl_r.aluop;
  assign illegal  = ctrl_r.illegal;

  assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(DW-5){ir[4]}}, ir[4:0]};

endmodule
